// File: rtl/axis_load_sequencer.sv
// Header-driven AXIS load sequencer: routes one payload burst to a one-hot DAC channel.
// Optional stall watchdog enabled by defining LOAD_TIMEOUT_EN.
module axis_load_sequencer #(
  parameter int unsigned NUM_CH         = 16,
  parameter int unsigned DATA_W         = 256,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [NUM_CH-1:0] channel_select,
  input  logic              abort,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] sel_q, sel_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [7:0]        hdr_id;
  logic [LEN_W-1:0]  hdr_len;
  logic [7:0]        hdr_magic;
  logic              hdr_ok;
  logic              in_load;
  logic              beat_hs;
  logic              last_beat;
  logic              timeout;

  // Header field decode; only meaningful while idle.
  assign hdr_id    = s_axis_tdata[7:0];
  assign hdr_len   = s_axis_tdata[16 +: LEN_W];
  assign hdr_magic = s_axis_tdata[DATA_W-1 -: 8];
  assign hdr_ok    = (hdr_magic == MAGIC) && (32'(hdr_id) < NUM_CH) && (hdr_len != '0);

  assign in_load   = (state_q == ST_LOAD);
  assign beat_hs   = in_load && s_axis_tvalid && m_axis_tready;
  assign last_beat = beat_hs && (remaining_q == LEN_W'(1));

  // Zero-latency payload path, gated so headers never leak downstream.
  assign m_axis_tdata  = in_load ? s_axis_tdata : '0;
  assign m_axis_tvalid = in_load && s_axis_tvalid;
  assign s_axis_tready = (state_q == ST_IDLE) || (in_load && m_axis_tready);

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Consecutive no-handshake cycles while loading.
  always_comb begin
    stall_d = '0;
    if (in_load && !beat_hs) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign timeout = in_load && !beat_hs && (stall_d == STALL_W'(TIMEOUT_CYCLES));

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic; completion outranks abort/timeout.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          if (hdr_ok) begin
            state_d     = ST_LOAD;
            sel_d       = NUM_CH'(1) << hdr_id;
            remaining_d = hdr_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (beat_hs) begin
          remaining_d = remaining_q - LEN_W'(1);
        end
        if (last_beat) begin
          state_d = ST_DONE;
          sel_d   = '0;
          done_d  = 1'b1;
        end else if (abort || timeout) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign channel_select = sel_q;
  assign busy           = busy_q;
  assign load_done      = done_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_axis_load_sequencer.sv
// Scoreboard bench for axis_load_sequencer: transaction-level model pushes expected
// beats/pulses; a negedge monitor pops and compares. Honours LOAD_TIMEOUT_EN.
module tb_axis_load_sequencer;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned TMO    = 8;
  localparam logic [7:0]  MAGIC  = 8'hA5;
  localparam int          EV_ERR  = 1;
  localparam int          EV_DONE = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NUM_CH-1:0] sel;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [NUM_CH-1:0] channel_select;
  logic              abort;
  logic              busy;
  logic              load_done;
  logic              load_err;

  beat_t             exp_beats[$];
  int                exp_evt[$];
  logic [NUM_CH-1:0] exp_sel;
  logic              exp_busy, exp_rdy, exp_mv, chk_en;
  int                n_cmp = 0;
  int                n_bad = 0;

  axis_load_sequencer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pl_clk(clk), .rst(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .channel_select(channel_select), .abort(abort), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(DATA_W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Monitor: per-cycle state expectations plus scoreboard pops on handshakes/pulses.
  always @(negedge clk) begin : mon
    beat_t b;
    int    e;
    if (rst_n && chk_en) begin
      cmp("channel_select", DATA_W'(channel_select), DATA_W'(exp_sel));
      cmp("busy", DATA_W'(busy), DATA_W'(exp_busy));
      cmp("s_axis_tready", DATA_W'(s_axis_tready), DATA_W'(exp_rdy));
      cmp("m_axis_tvalid", DATA_W'(m_axis_tvalid), DATA_W'(exp_mv));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beats.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: actual %0h required no beat at %0t", m_axis_tdata, $time);
        end else begin
          b = exp_beats.pop_front();
          cmp("beat_data", m_axis_tdata, b.data);
          cmp("beat_sel", DATA_W'(channel_select), DATA_W'(b.sel));
        end
      end
      if (load_done || load_err) begin
        if (exp_evt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_pulse: actual done=%0b err=%0b required none at %0t",
                   load_done, load_err, $time);
        end else begin
          e = exp_evt.pop_front();
          cmp("pulse", DATA_W'({load_done, load_err}), DATA_W'(e));
        end
      end
    end
  end

  // One clock of stimulus; st is the model's state for this cycle (0 idle, 1 load, 2 done).
  task automatic step(input logic tv, input logic [DATA_W-1:0] d, input logic mr,
                      input logic ab, input int st, input int id);
    @(posedge clk); #1;
    s_axis_tvalid = tv;
    s_axis_tdata  = d;
    m_axis_tready = mr;
    abort         = ab;
    exp_sel  = (st == 1) ? (NUM_CH'(1) << id) : '0;
    exp_busy = (st != 0);
    exp_rdy  = (st == 0) || (st == 1 && mr);
    exp_mv   = (st == 1) && tv;
    chk_en   = 1'b1;
  endtask

  task automatic idle_step();
    step(1'b0, rand_data(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
  endtask

  // tv_mode: 0 random, 1 always, 2 low for 12 cycles then high.
  // tr_mode: 0 random, 1 always, 2 toggle. abort_at: -1 never, -2 random, else at that beat count.
  task automatic run_load(input int id, input int len, input logic [7:0] magic,
                          input int tv_mode, input int tr_mode, input int abort_at,
                          input logic done_abort);
    logic [DATA_W-1:0] d;
    logic tv, mr, ab;
    int cnt, stall, k;
    d = rand_data();
    d[7:0] = 8'(id);
    d[16 +: LEN_W] = LEN_W'(len);
    d[DATA_W-1 -: 8] = magic;
    step(1'b1, d, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    if (!(magic == MAGIC && id >= 0 && id < int'(NUM_CH) && len != 0)) begin
      exp_evt.push_back(EV_ERR);
      return;
    end
    cnt = 0; stall = 0; k = 0;
    forever begin
      tv = (tv_mode == 0) ? ($urandom_range(0, 3) != 0) : (tv_mode == 2) ? (k >= 12) : 1'b1;
      mr = (tr_mode == 0) ? ($urandom_range(0, 3) != 0) : (tr_mode == 2) ? (k % 2 == 0) : 1'b1;
      ab = (abort_at >= 0 && cnt == abort_at) || (abort_at == -2 && $urandom_range(0, 15) == 0);
      d  = rand_data();
      step(tv, d, mr, ab, 1, id);
      k++;
      if (tv && mr) begin
        exp_beats.push_back('{d, NUM_CH'(1) << id});
        cnt++;
        stall = 0;
        if (cnt == len) begin
          exp_evt.push_back(EV_DONE);
          break;
        end
      end else begin
        stall++;
      end
      if (ab) begin
        exp_evt.push_back(EV_ERR);
        return;
      end
`ifdef LOAD_TIMEOUT_EN
      if (stall == int'(TMO)) begin
        exp_evt.push_back(EV_ERR);
        return;
      end
`endif
    end
    step(1'($urandom_range(0, 1)), rand_data(), 1'b1, done_abort, 2, id);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_select"}, DATA_W'(channel_select), '0);
    cmp({tag, "_busy"}, DATA_W'(busy), '0);
    cmp({tag, "_s_tready"}, DATA_W'(s_axis_tready), DATA_W'(1));
    cmp({tag, "_m_tvalid"}, DATA_W'(m_axis_tvalid), '0);
    cmp({tag, "_m_tdata"}, m_axis_tdata, '0);
    cmp({tag, "_done"}, DATA_W'(load_done), '0);
    cmp({tag, "_err"}, DATA_W'(load_err), '0);
  endtask

  task automatic reset_mid();
    logic [DATA_W-1:0] d;
    d = rand_data();
    d[7:0] = 8'd7;
    d[16 +: LEN_W] = LEN_W'(10);
    d[DATA_W-1 -: 8] = MAGIC;
    step(1'b1, d, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      d = rand_data();
      step(1'b1, d, 1'b1, 1'b0, 1, 7);
      exp_beats.push_back('{d, NUM_CH'(1) << 7});
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; chk_en = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = rand_data(); m_axis_tready = 1'b1; abort = 1'b0;
    exp_sel = '0; exp_busy = 1'b0; exp_rdy = 1'b1; exp_mv = 1'b0;
    #2;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    idle_step(); idle_step();

    run_load(3, 4, MAGIC, 1, 1, -1, 1'b0);
    run_load(3, 4, 8'h5A, 1, 1, -1, 1'b0);
    run_load(16, 4, MAGIC, 1, 1, -1, 1'b0);
    run_load(5, 0, MAGIC, 1, 1, -1, 1'b0);
    run_load(2, 2, MAGIC, 1, 1, -1, 1'b0);
    idle_step();
    run_load(15, 3, MAGIC, 1, 2, -1, 1'b0);
    run_load(9, 5, MAGIC, 1, 1, 2, 1'b0);
    run_load(4, 2, MAGIC, 1, 1, 1, 1'b1);
    run_load(6, 3, MAGIC, 2, 1, -1, 1'b0);
    run_load(0, 1, MAGIC, 0, 0, -1, 1'b1);
    reset_mid();
    run_load(7, 3, MAGIC, 1, 1, -1, 1'b0);

    repeat (80) begin
      int id, len, ab_at;
      logic [7:0] mg;
      id    = $urandom_range(0, 19);
      len   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      mg    = ($urandom_range(0, 9) == 0) ? 8'h5A : MAGIC;
      ab_at = ($urandom_range(0, 3) == 0) ? -2 : -1;
      run_load(id, len, mg, 0, 0, ab_at, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) idle_step();
    end

    repeat (3) idle_step();
    @(negedge clk); #1;
    chk_en = 1'b0;
    cmp("beats_left", DATA_W'(exp_beats.size()), '0);
    cmp("pulses_left", DATA_W'(exp_evt.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_load_sequencer.md
# axis_load_sequencer

Sequences PS-to-PL waveform loads into the per-channel DAC drivers without the PS toggling GPIO channel-select bits. Sits in the pl_clk domain between the PS-to-PL width/clock-crossing output and the AXIS channel selector. It parses a header beat carrying channel ID and payload length, drives a one-hot channel select for exactly that many payload beats, then releases the channel and reports completion or error.

## Interface
- NUM_CH, 16, number of DAC channels; one-hot select width
- DATA_W, 256, AXIS data width
- LEN_W, 16, width of payload length field (beats)
- TIMEOUT_CYCLES, 4096, stall watchdog limit; used only with LOAD_TIMEOUT_EN
- pl_clk  in  1  sole clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_W  header and payload stream from PS crossing
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  DATA_W  payload to channel selector
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  ready from selected channel
- channel_select  out  NUM_CH  one-hot target channel; all-zero when not loading
- abort  in  1  synchronous request to cancel the current load
- busy  out  1  high in LOAD and DONE
- load_done  out  1  one-cycle pulse on successful load completion
- load_err  out  1  one-cycle pulse on rejected header, abort, or timeout

## Operation
- Header beat fields: [7:0] channel ID, [16+LEN_W-1:16] length in beats, [255:248] magic 8'hA5. Remaining bits are ignored.
- IDLE: s_axis_tready=1, m_axis_tvalid=0, channel_select=0. On s_axis_tvalid, the header is consumed.
  - Valid header (magic ok, ID < NUM_CH, length != 0): latch ID and length, go to LOAD.
  - Otherwise: pulse load_err and stay in IDLE.
- LOAD: channel_select = 1<<ID. Combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready. The remaining-beat counter decrements on each s_axis_tvalid&&m_axis_tready. On acceptance of the beat with remaining==1, go to DONE.
- DONE: one cycle. channel_select=0, s_axis_tready=0, load_done=1. Then go to IDLE.
- Abort in LOAD: on the next edge go to IDLE, pulse load_err, clear channel_select. Any beat accepted in the abort cycle counts normally.
- Abort with last-beat acceptance in the same cycle: completion wins. Go to DONE; no load_err.
- Abort in IDLE or DONE has no effect.
- Payload beats are never interpreted as headers. The header beat is never forwarded downstream.

## Timing
- Reset values: state=IDLE, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0 (pass-through is gated by state), channel_select=0, busy=0, load_done=0, load_err=0, counter=0.
- Header acceptance to channel_select asserted: 1 cycle. The first payload beat can be accepted in the cycle immediately after the header.
- Payload latency: 0 cycles (combinational). The data path has no buffering.
- Last beat accepted at edge N: DONE during cycle N+1, IDLE at N+2. The next header is accepted no earlier than N+2, giving at least 1 dead cycle between loads.
- load_done and load_err are registered single-cycle pulses and are never asserted together.
- Length L: exactly L payload handshakes occur. The maximum is 2^LEN_W-1 beats; there is no wrap.
- Reset mid-LOAD: immediate return to IDLE with select cleared. Partial data in the channel is not cleaned up here.

## Configuration
- LOAD_TIMEOUT_EN defined: in LOAD, a stall counter increments each cycle without a payload handshake and clears on each handshake. When it reaches TIMEOUT_CYCLES, the block goes to IDLE, pulses load_err and clears channel_select. Timeout and last-beat acceptance in the same cycle resolve as completion.
- LOAD_TIMEOUT_EN undefined: no stall counter is present. LOAD waits indefinitely and exits only via completion, abort, or reset.

## Test plan
- Header ID=3, len=4, magic A5, then 4 beats with tready held high -> channel_select=16'h0008 for 4 cycles, 4 beats out unchanged, load_done one cycle later, select back to 0.
- Header with magic 8'h5A, or ID=16, or len=0 -> load_err pulse, channel_select stays 0, the next valid header is accepted normally.
- ID=15, len=3, tready toggled 1/0 every cycle -> exactly 3 handshakes, no beat duplicated or dropped, load_done after the third handshake.
- Abort asserted after 2 of 5 beats -> load_err, select cleared; abort coincident with the last beat of len=2 -> load_done only.
- Reset asserted mid-LOAD (ID=7) -> all outputs at reset values asynchronously; after release, a new header loads correctly.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8: tvalid held low for 8 cycles in LOAD -> load_err at the 8th stalled cycle; without the macro, the same stimulus stays in LOAD.
